// File: rtl/adder_subtractor_pkg.sv
// rtl/adder_subtractor_pkg.sv - shared constants for the adder/subtractor
//
// Purpose: mode encodings and default operand width used by the datapath.
// Ports:   none (package).
package adder_subtractor_pkg;

    localparam logic MODE_ADD      = 1'b0;
    localparam logic MODE_SUB      = 1'b1;
    localparam int   DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell for the ripple-carry chain
//
// Purpose: combinational single-bit add with carry in and carry out.
// Ports:
//   x, y  - operand bits
//   cin   - carry in from the lower bit
//   s     - sum bit
//   cout  - carry out to the next bit
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = x ^ y;
    assign s    = p ^ cin;
    assign cout = (x & y) | (cin & p);

endmodule

// File: rtl/adder_subtractor_4bit.sv
// rtl/adder_subtractor_4bit.sv - registered ripple-carry adder/subtractor
//
// Purpose: d = a + b (M=0) or a - b (M=1), modulo 2^WIDTH, with carry (add)
//          or borrow (subtract) on bout; one-cycle latency, one op per cycle.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears d and bout
//   a, b  - unsigned operands
//   M     - mode: 0 add, 1 subtract
//   d     - registered result
//   bout  - registered carry-out (add) or borrow (subtract)
module adder_subtractor_4bit
    import adder_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             M,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    logic             flag;

    // Subtraction is a + ~b + 1: invert b and feed the mode bit in as carry-in.
    assign b_eff    = b ^ {WIDTH{M}};
    assign carry[0] = M;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .x    (a[i]),
            .y    (b_eff[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    // In subtract mode a chain carry-out means "no borrow", so invert it.
    assign flag = (M == MODE_SUB) ? ~carry[WIDTH] : carry[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d    <= '0;
            bout <= 1'b0;
        end else begin
            d    <= sum;
            bout <= flag;
        end
    end

endmodule

// File: tb/tb_adder_subtractor_4bit.sv
// tb/tb_adder_subtractor_4bit.sv - scoreboard bench for adder_subtractor_4bit
module tb_adder_subtractor_4bit;

    typedef struct {
        int d;
        int c;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       m;
    logic [3:0] d;
    logic       bout;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    adder_subtractor_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .M     (m),
        .d     (d),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input int av, input int bv, input int mv);
        exp_t r;
        if (mv == 0) begin
            r.d = (av + bv) % 16;
            r.c = ((av + bv) >= 16) ? 1 : 0;
        end else begin
            r.d = (av - bv + 16) % 16;
            r.c = (av < bv) ? 1 : 0;
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic apply(input int av, input int bv, input int mv);
        @(negedge clk);
        a = 4'(av);
        b = 4'(bv);
        m = 1'(mv);
        exp_q.push_back(model(av, bv, mv));
    endtask

    // Monitor: every edge out of reset with an issued operation pending
    // produces one result to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                #1;
                check("d", int'(d), e.d);
                check("bout", int'(bout), e.c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        a = 4'd15;
        b = 4'd15;
        m = 1'b0;
        #1;
        check("reset_d_t0", int'(d), 0);
        check("reset_bout_t0", int'(bout), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_d_hold", int'(d), 0);
            check("reset_bout_hold", int'(bout), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model(15, 15, 0));

        // Directed add / subtract / borrow cases
        apply(5, 3, 0);  apply(9, 6, 0);  apply(15, 1, 0);
        apply(8, 3, 1);  apply(6, 2, 1);  apply(15, 1, 1);
        apply(3, 5, 1);  apply(0, 1, 1);  apply(7, 7, 1);

        // Back-to-back mode alternation
        for (int i = 0; i < 8; i++) apply(10, 12, i % 2);

        // Inputs changing between edges must not disturb the held result
        apply(5, 3, 0);
        @(posedge clk);
        #2;
        a = 4'd0;
        b = 4'd0;
        m = 1'b1;
        @(negedge clk);
        check("hold_d", int'(d), 8);
        check("hold_bout", int'(bout), 0);

        // Asynchronous reset in mid-operation
        apply(9, 6, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_d", int'(d), 0);
        check("async_reset_bout", int'(bout), 0);
        @(negedge clk);
        check("reset_held_d", int'(d), 0);
        a = 4'd2;
        b = 4'd9;
        m = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model(2, 9, 1));

        // Exhaustive sweep
        for (int mv = 0; mv < 2; mv++)
            for (int av = 0; av < 16; av++)
                for (int bv = 0; bv < 16; bv++)
                    apply(av, bv, mv);

        // Random sweep
        for (int i = 0; i < 200; i++)
            apply(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)));

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_subtractor_4bit.md
ADDER_SUBTRACTOR_4BIT -- requirements
Module: adder_subtractor_4bit

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 4, operand/result width in bits; only the default is required to be verified.
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: a  input  WIDTH  minuend/augend, unsigned.
REQ-006 Port: b  input  WIDTH  subtrahend/addend, unsigned.
REQ-007 Port: M  input  1  mode select: 0 = add (a+b), 1 = subtract (a-b).
REQ-008 Port: d  output  WIDTH  registered result, modulo 2^WIDTH.
REQ-009 Port: bout  output  1  registered carry (add mode) or borrow (subtract mode).

Function
REQ-010 Datapath SHALL compute sum = a + (b XOR {WIDTH{M}}) + M, a single ripple-carry chain with carry-in = M.
REQ-011 Add mode (M=0): d SHALL be (a+b) mod 2^WIDTH; bout SHALL be the carry out of the MSB (1 when a+b >= 2^WIDTH).
REQ-012 Subtract mode (M=1): d SHALL be (a-b) mod 2^WIDTH, i.e. the two's-complement difference; bout SHALL be 1 exactly when a < b (borrow = inverted chain carry-out).
REQ-013 a == b in subtract mode SHALL give d=0, bout=0.
REQ-014 d and bout SHALL be registered: values computed from a, b, M sampled at rising edge N SHALL appear on d/bout after edge N and hold until edge N+1; latency exactly 1 cycle, throughput one operation per cycle.
REQ-015 Input changes between edges SHALL have no effect on d/bout until the next rising edge.
REQ-016 M changes SHALL take effect on the same edge as a/b; there is no mode pipelining or hazard.
REQ-017 There SHALL be no handshake; every edge out of reset loads a new result.
REQ-018 No X SHALL propagate to d/bout when inputs are known.

Reset
REQ-019 While rst_n=0, d SHALL be 0 and bout SHALL be 0, asynchronously, regardless of clk.
REQ-020 The first rising edge with rst_n=1 SHALL load the result of the inputs present at that edge.
REQ-021 Reset asserted mid-operation SHALL discard the pending result; no state survives reset.

Structure
REQ-022 A shared package adder_subtractor_pkg SHALL hold constants MODE_ADD=1'b0 and MODE_SUB=1'b1 and the default width constant (4).
REQ-023 One sub-module full_adder (inputs x, y, cin; outputs s, cout) SHALL be instantiated WIDTH times in a generate loop to form the ripple chain.
REQ-024 b-inversion XORs, borrow inversion and the output register SHALL live in adder_subtractor_4bit.

Verification
REQ-025 Reset: rst_n=0 with a=15, b=15, M=0 clocking -> d=0, bout=0 throughout; after release, next edge -> d=14, bout=1.
REQ-026 Add: M=0, a=5,b=3 -> d=8,bout=0; a=9,b=6 -> d=15,bout=0; a=15,b=1 -> d=0,bout=1 (each one cycle later).
REQ-027 Subtract: M=1, a=8,b=3 -> d=5,bout=0; a=6,b=2 -> d=4,bout=0; a=15,b=1 -> d=14,bout=0.
REQ-028 Borrow: M=1, a=3,b=5 -> d=14 (-2),bout=1; a=0,b=1 -> d=15,bout=1; a=7,b=7 -> d=0,bout=0.
REQ-029 Back-to-back: alternate M each cycle with a=10,b=12 -> d alternates 6/14, bout=1 every cycle, with 1-cycle latency.
REQ-030 Exhaustive: all 512 (a,b,M) combinations, one per cycle, compared against a reference model -> zero mismatches.
